multi_blink: RTL and testbench
==============================

Name: multi_blink

Overview:
- Parametrised multi-channel LED blinker; each channel independently drives one LED with a programmable OFF/ON period and mode.
- Sits between the board clock and the LED pins.
- Runtime reconfiguration through a valid/ready config port; global enable freezes all channels.
- Out of reset, every channel free-runs with default periods.

Parameters:
- CHANNELS, 4, number of independent LED channels (1..16).
- CNT_W, 27, width of per-channel period counter and period fields.
- DEF_OFF, 25000000, reset OFF-phase length in clk cycles.
- DEF_ON, 50000000, reset ON-phase length in clk cycles.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = counters advance; 0 = all counters and LEDs hold.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; transfer when cfg_valid && cfg_ready.
- cfg_ch  in  4  target channel index.
- cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 ONESHOT.
- cfg_off  in  CNT_W  OFF-phase length in cycles.
- cfg_on  in  CNT_W  ON-phase length in cycles.
- cfg_err  out  1  one-cycle pulse: accepted transfer had cfg_ch >= CHANNELS.
- led  out  CHANNELS  LED drive, registered.
- cycle_done  out  CHANNELS  one-cycle pulse per channel at the end of each ON phase.

Behaviour:
- Reset (async assert, sync release):
  - led=0, cycle_done=0, cfg_err=0, cfg_ready=0.
  - Every channel: mode=BLINK, off_len=DEF_OFF, on_len=DEF_ON, phase=OFF_PH, cnt=0.
- cfg_ready goes 1 on the first clk edge after rst_n deasserts and stays 1 thereafter.
- Per-channel state: mode[1:0], off_len, on_len, cnt[CNT_W-1:0], phase {OFF_PH, ON_PH}.
- Effective length = max(len,1); a programmed 0 means 1 cycle. Counter never wraps: it is reset to 0 at each terminal count.
- Mode OFF: led=0, cnt held at 0, no cycle_done.
- Mode ON: led=1, cnt held at 0, no cycle_done.
- Mode BLINK, with enable=1 each cycle:
  - OFF_PH:
    - cnt == eff_off-1: phase<=ON_PH, cnt<=0, led<=1.
    - else cnt<=cnt+1.
  - ON_PH:
    - cnt == eff_on-1: phase<=OFF_PH, cnt<=0, led<=0, cycle_done<=1 for one cycle.
    - else cnt<=cnt+1.
  - Steady-state LED period = eff_off+eff_on cycles. led rises exactly eff_off cycles after phase entry.
- Mode ONESHOT: same as BLINK, except at the ON_PH terminal count mode<=OFF (cycle_done still pulses once). Channel then stays dark until reconfigured.
- Config accept (cfg_valid && cfg_ready, cfg_ch < CHANNELS):
  - Next edge: target channel loads mode/off_len/on_len, phase<=OFF_PH, cnt<=0.
  - led is set per the new mode: 1 if ON, else 0.
  - Other channels are unaffected.
- Config accept with cfg_ch >= CHANNELS: no state change; cfg_err=1 next cycle for one cycle.
- Simultaneous config and terminal count on the same channel: config wins; no cycle_done that cycle.
- Config is accepted while enable=0; the new state is loaded and then held.
- enable=0: cnt, phase, and led frozen; cycle_done=0.
- Reset mid-period: immediate return to reset values; prior config is lost.
- Channels are fully independent; any number may pulse cycle_done in the same cycle.

Optional Feature:
- Macro: MULTI_BLINK_STAGGER_EN.
- Defined: at reset, channel i has cnt preloaded to (i*DEF_OFF)/CHANNELS, truncated, so channel OFF phases end staggered. Reconfiguration still clears cnt to 0.
- Undefined: all channels reset with cnt=0 and blink in lockstep.

Test Plan (CHANNELS=4, CNT_W=8, DEF_OFF=2, DEF_ON=4, macro undefined unless stated):
- Release reset, enable=1 -> all led rise 2 cycles after first active edge, stay high 4 cycles; cycle_done pulses every 6 cycles on all channels together.
- Config ch1 ONESHOT off=3 on=1 -> led[1] high for exactly 1 cycle after 3 cycles, one cycle_done[1] pulse, then led[1]=0 permanently; channels 0,2,3 undisturbed.
- Config ch2 off=0 on=0 BLINK -> led[2] toggles every cycle; cycle_done[2] every 2 cycles.
- Drop enable for 5 cycles mid ON phase -> led and cnt hold; resume finishes the remaining ON cycles exactly, period shifted by 5.
- Config with cfg_ch=7 -> cfg_err single pulse, no led change; config landing on ch0's ON terminal-count cycle -> no cycle_done[0], ch0 restarts in OFF_PH.
- Define MULTI_BLINK_STAGGER_EN, DEF_OFF=8 -> after reset the first led rising edges of channels 0..3 occur 8,6,4,2 cycles after release.

Source files
------------

// File: rtl/multi_blink.sv
// Multi-channel LED blinker: each channel runs OFF/ON/BLINK/ONESHOT with its own
// programmable phase lengths. Define MULTI_BLINK_STAGGER_EN to stagger channel counters at reset.
module multi_blink #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 27,
  parameter int DEF_OFF  = 25000000,
  parameter int DEF_ON   = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_off,
  input  logic [CNT_W-1:0]    cfg_on,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] cycle_done
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  typedef enum logic {
    OFF_PH = 1'b0,
    ON_PH  = 1'b1
  } phase_t;

  localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_OFF_L = CNT_W'(DEF_OFF);
  localparam logic [CNT_W-1:0] DEF_ON_L  = CNT_W'(DEF_ON);
  localparam logic [4:0]       CH_LIM    = 5'(CHANNELS);

  logic r_ready;
  logic r_err;
  logic w_fire;
  logic w_bad_ch;

  assign w_fire    = cfg_valid & r_ready;
  assign w_bad_ch  = ({1'b0, cfg_ch} >= CH_LIM);
  assign cfg_ready = r_ready;
  assign cfg_err   = r_err;

  // Ready rises on the first edge after reset release; error pulses on out-of-range targets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_fire & w_bad_ch;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
`ifdef MULTI_BLINK_STAGGER_EN
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((gi * DEF_OFF) / CHANNELS);
`else
    localparam logic [CNT_W-1:0] CNT_INIT = {CNT_W{1'b0}};
`endif

    mode_t            r_mode;
    phase_t           r_phase;
    logic [CNT_W-1:0] r_off;
    logic [CNT_W-1:0] r_on;
    logic [CNT_W-1:0] r_cnt;
    logic             r_led;
    logic             r_done;
    logic             w_load;
    logic [CNT_W-1:0] w_off_last;
    logic [CNT_W-1:0] w_on_last;

    // A programmed length of 0 behaves as 1 cycle.
    assign w_load     = w_fire & (cfg_ch == 4'(gi));
    assign w_off_last = (r_off == ZERO) ? ZERO : (r_off - ONE);
    assign w_on_last  = (r_on == ZERO) ? ZERO : (r_on - ONE);

    assign led[gi]        = r_led;
    assign cycle_done[gi] = r_done;

    // Per-channel sequencer: config load takes priority over any terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mode  <= MODE_BLINK;
        r_phase <= OFF_PH;
        r_off   <= DEF_OFF_L;
        r_on    <= DEF_ON_L;
        r_cnt   <= CNT_INIT;
        r_led   <= 1'b0;
        r_done  <= 1'b0;
      end else if (w_load) begin
        r_mode  <= mode_t'(cfg_mode);
        r_phase <= OFF_PH;
        r_off   <= cfg_off;
        r_on    <= cfg_on;
        r_cnt   <= ZERO;
        r_led   <= (cfg_mode == 2'b01);
        r_done  <= 1'b0;
      end else if (!enable) begin
        r_done  <= 1'b0;
      end else begin
        r_done <= 1'b0;
        case (r_mode)
          MODE_OFF: begin
            r_led <= 1'b0;
            r_cnt <= ZERO;
          end
          MODE_ON: begin
            r_led <= 1'b1;
            r_cnt <= ZERO;
          end
          default: begin
            if (r_phase == OFF_PH) begin
              if (r_cnt == w_off_last) begin
                r_phase <= ON_PH;
                r_cnt   <= ZERO;
                r_led   <= 1'b1;
              end else begin
                r_cnt <= r_cnt + ONE;
              end
            end else begin
              if (r_cnt == w_on_last) begin
                r_phase <= OFF_PH;
                r_cnt   <= ZERO;
                r_led   <= 1'b0;
                r_done  <= 1'b1;
                if (r_mode == MODE_ONESHOT) begin
                  r_mode <= MODE_OFF;
                end else begin
                  r_mode <= r_mode;
                end
              end else begin
                r_cnt <= r_cnt + ONE;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_blink.sv
// Scoreboard bench for multi_blink: a position-in-period model predicts every cycle's
// outputs, which a separate monitor compares one cycle after each active edge.
module tb_multi_blink;

  localparam int CH      = 4;
  localparam int CW      = 8;
  localparam int D_OFF   = 2;
  localparam int D_ON    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [3:0]    cfg_ch = 4'd0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [CW-1:0] cfg_off = 8'd0;
  logic [CW-1:0] cfg_on = 8'd0;
  logic          cfg_err;
  logic [CH-1:0] led;
  logic [CH-1:0] cycle_done;

  multi_blink #(.CHANNELS(CH), .CNT_W(CW), .DEF_OFF(D_OFF), .DEF_ON(D_ON)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_off(cfg_off), .cfg_on(cfg_on),
    .cfg_err(cfg_err), .led(led), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [CH-1:0] led;
    logic [CH-1:0] done;
    logic          err;
    logic          ready;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: each blinking channel is just a position k within its period.
  int   m_mode[CH];
  int   m_off[CH];
  int   m_on[CH];
  int   m_k[CH];
  logic [CH-1:0] m_led;
  bit   m_ready;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (led !== e.led || cycle_done !== e.done || cfg_err !== e.err || cfg_ready !== e.ready) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d led=%b exp=%b done=%b exp=%b err=%b exp=%b ready=%b exp=%b",
                 e.cyc, led, e.led, cycle_done, e.done, cfg_err, e.err, cfg_ready, e.ready);
      end
    end
  end

  function automatic int eff(input int len);
    return (len == 0) ? 1 : len;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_mode[i] = 2;
      m_off[i]  = D_OFF;
      m_on[i]   = D_ON;
`ifdef MULTI_BLINK_STAGGER_EN
      m_k[i]    = (i * D_OFF) / CH;
`else
      m_k[i]    = 0;
`endif
    end
    m_led   = '0;
    m_ready = 1'b0;
  endtask

  task automatic step(input bit rlo, input bit en, input bit v, input int ch,
                      input int md, input int off, input int on);
    exp_t e;
    bit   fire;
    @(negedge clk);
    rst_n     = !rlo;
    enable    = en;
    cfg_valid = v;
    cfg_ch    = 4'(ch);
    cfg_mode  = 2'(md);
    cfg_off   = 8'(off);
    cfg_on    = 8'(on);
    e.err  = 1'b0;
    e.done = '0;
    if (rlo) begin
      model_reset();
    end else begin
      fire    = v && m_ready;
      m_ready = 1'b1;
      if (fire && ch >= CH) e.err = 1'b1;
      for (int i = 0; i < CH; i++) begin
        if (fire && ch == i) begin
          m_mode[i] = md;
          m_off[i]  = off;
          m_on[i]   = on;
          m_k[i]    = 0;
          m_led[i]  = (md == 1);
        end else if (en) begin
          if (m_mode[i] == 0) m_led[i] = 1'b0;
          else if (m_mode[i] == 1) m_led[i] = 1'b1;
          else begin
            m_k[i]++;
            if (m_k[i] == eff(m_off[i]) + eff(m_on[i])) begin
              m_k[i]    = 0;
              e.done[i] = 1'b1;
              if (m_mode[i] == 3) m_mode[i] = 0;
            end
            m_led[i] = (m_k[i] >= eff(m_off[i]));
          end
        end
      end
    end
    e.led   = m_led;
    e.ready = m_ready;
    e.cyc   = cyc + 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    // Default free-running blink in lockstep
    idle(20, 1'b1);
    // ONESHOT on ch1, then 0/0 BLINK on ch2
    step(1'b0, 1'b1, 1'b1, 1, 3, 3, 1);
    idle(12, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2, 2, 0, 0);
    idle(8, 1'b1);
    // Freeze mid-phase, including a config while frozen
    idle(3, 1'b1);
    idle(5, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3, 2, 1, 2);
    idle(3, 1'b0);
    idle(10, 1'b1);
    // Out-of-range channel
    step(1'b0, 1'b1, 1'b1, 7, 1, 5, 5);
    idle(4, 1'b1);
    // Config landing on ch0's ON terminal count
    step(1'b0, 1'b1, 1'b1, 0, 2, 2, 3);
    for (int i = 0; i < 20; i++) begin
      if (m_k[0] == eff(m_off[0]) + eff(m_on[0]) - 1) break;
      step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    end
    step(1'b0, 1'b1, 1'b1, 0, 2, 1, 1);
    idle(8, 1'b1);
    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      step(1'b0, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 12),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
    end
    // Reset mid-period then resume defaults
    step(1'b0, 1'b1, 1'b1, 1, 1, 0, 0);
    idle(3, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
    idle(20, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
